// File: rtl/dcache_line_mem_if.sv
// Request/response bundle between the dcache controller (master) and the
// line-wide backing memory (slave).
//   enable_i  request valid, held by the controller until it samples ack_o=1
//   write_i   1 = write-back, 0 = refill read
//   addr_i    byte address, line aligned (low 5 bits ignored)
//   data_i    write line data
//   ack_o     one-cycle completion pulse
//   data_o    read line data, valid while ack_o=1 on a read
//   busy_o    a request is outstanding
interface dcache_line_mem_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
);
   logic              enable_i;
   logic              write_i;
   logic [ADDR_W-1:0] addr_i;
   logic [LINE_W-1:0] data_i;
   logic              ack_o;
   logic [LINE_W-1:0] data_o;
   logic              busy_o;

   modport master (
      output enable_i, write_i, addr_i, data_i,
      input  ack_o, data_o, busy_o
   );

   modport slave (
      input  enable_i, write_i, addr_i, data_i,
      output ack_o, data_o, busy_o
   );
endinterface

// File: rtl/dcache_line_mem.sv
// Line-wide backing data memory below the dcache controller. Serves one
// refill read or dirty-line write-back at a time; every request completes a
// fixed LATENCY cycles after acceptance and is closed by a one-cycle ack.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-low reset (array contents are kept)
//   bus    dcache_line_mem_if slave: enable_i/write_i/addr_i/data_i in,
//          ack_o/data_o/busy_o out
module dcache_line_mem #(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 256,
   parameter int DEPTH   = 512,
   parameter int LATENCY = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   dcache_line_mem_if.slave  bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [IDX_W-1:0]  idx_q;
   logic              wr_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] data_q;
   logic              last;
   logic              mem_we;

   logic [LINE_W-1:0] mem [DEPTH];

   // Exit from WAIT happens at LATENCY-1, so cnt never needs to wrap.
   assign last   = (cnt_q == CNT_W'(LATENCY - 1));
   assign mem_we = (state_q == WAIT) && last && wr_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.enable_i) state_d = WAIT;
         WAIT:    if (last)         state_d = ACK;
         ACK:                       state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   // Request fields are captured at acceptance so the controller may change
   // its inputs while the request is in flight.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (bus.enable_i) begin
                  idx_q   <= bus.addr_i[5 +: IDX_W];
                  wr_q    <= bus.write_i;
                  wdata_q <= bus.data_i;
                  cnt_q   <= '0;
               end
            end
            WAIT: begin
               if (last) begin
                  if (!wr_q) data_q <= mem[idx_q];
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Array has no reset; an aborted request never reaches mem_we because
   // reset forces the state back to IDLE.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem[idx_q] <= wdata_q;
   end

   assign bus.ack_o  = (state_q == ACK);
   assign bus.busy_o = (state_q != IDLE);
   assign bus.data_o = data_q;
endmodule

// File: tb/tb_dcache_line_mem.sv
module tb_dcache_line_mem;
   localparam int LAT = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   failures = 0;

   dcache_line_mem_if #(.ADDR_W(32), .LINE_W(256)) bus ();

   dcache_line_mem #(.ADDR_W(32), .LINE_W(256), .DEPTH(512), .LATENCY(LAT)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue a request starting just after a negedge; waits for ack (bounded),
   // checks ack timing and that busy was high for the LAT cycles before ack.
   // exp_lat counts negedges after the first posedge until ack is seen.
   // Returns at the negedge where ack_o=1 was sampled, with enable dropped.
   task automatic run_req(input string tag, input logic wr, input logic [31:0] a,
                          input logic [255:0] d, input int exp_lat, input bit scramble);
      int j;
      int busy_low;
      bit seen;
      j = 0; busy_low = 0; seen = 0;
      bus.enable_i = 1'b1;
      bus.write_i  = wr;
      bus.addr_i   = a;
      bus.data_i   = d;
      @(posedge clk);
      while (j < 40) begin
         @(negedge clk);
         if (bus.ack_o === 1'b1) begin
            seen = 1;
            break;
         end
         if (j >= exp_lat - LAT && bus.busy_o !== 1'b1) busy_low++;
         if (scramble && j == 0) begin
            bus.addr_i  = 32'hC0;
            bus.data_i  = {8{32'hDEAD_BEEF}};
            bus.write_i = ~wr;
         end
         j++;
      end
      bus.enable_i = 1'b0;
      chk({tag, "_ack_seen"}, 256'(seen), 256'(1));
      chk({tag, "_latency"}, 256'(j), 256'(exp_lat));
      chk({tag, "_busy_wait"}, 256'(busy_low), 256'(0));
      chk({tag, "_busy_ack"}, 256'(bus.busy_o), 256'(1));
   endtask

   initial begin
      logic [255:0] a5, p6, p8, z0, d0, w1234;
      int acks;
      a5    = {32{8'hA5}};
      p6    = {8{32'h6666_0006}};
      p8    = {8{32'h8888_0008}};
      z0    = {8{32'h0BAD_F00D}};
      d0    = {8{32'h0D0D_0D0D}};
      w1234 = 256'h1234;

      bus.enable_i = 1'b0;
      bus.write_i  = 1'b0;
      bus.addr_i   = '0;
      bus.data_i   = '0;

      dut.mem[0] = z0;
      dut.mem[3] = a5;
      dut.mem[6] = p6;
      dut.mem[8] = p8;

      // T1: asynchronous reset mid-cycle
      #13 rst_n = 1'b0;
      #1;
      chk("t1_ack_rst", 256'(bus.ack_o), 256'(0));
      chk("t1_busy_rst", 256'(bus.busy_o), 256'(0));
      chk("t1_data_rst", bus.data_o, 256'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      acks = 0;
      repeat (50) begin
         @(negedge clk);
         if (bus.ack_o !== 1'b0 || bus.busy_o !== 1'b0) acks++;
      end
      chk("t1_idle_50", 256'(acks), 256'(0));

      // T2: read latency, idx 3
      run_req("t2_rd", 1'b0, 32'h60, '0, LAT, 1'b0);
      chk("t2_data", bus.data_o, a5);
      @(negedge clk);
      chk("t2_ack_drop", 256'(bus.ack_o), 256'(0));
      chk("t2_busy_drop", 256'(bus.busy_o), 256'(0));
      chk("t2_data_hold", bus.data_o, a5);

      // T3: write then read same line; read chained directly after write ack
      // (ACK edge, one IDLE cycle, then LAT cycles => 11 negedges)
      run_req("t3_wr", 1'b1, 32'h80, w1234, LAT, 1'b0);
      chk("t3_data_on_wr_ack", bus.data_o, a5);
      run_req("t3_rd", 1'b0, 32'h80, '0, LAT + 1, 1'b0);
      chk("t3_rd_data", bus.data_o, w1234);
      @(negedge clk);

      // T4: inputs changed during WAIT do not affect the in-flight write
      run_req("t4_wr", 1'b1, 32'h40, d0, LAT, 1'b1);
      @(negedge clk);
      @(negedge clk);
      run_req("t4_rd2", 1'b0, 32'h40, '0, LAT, 1'b0);
      chk("t4_mem2", bus.data_o, d0);
      @(negedge clk);
      @(negedge clk);
      run_req("t4_rd6", 1'b0, 32'hC0, '0, LAT, 1'b0);
      chk("t4_mem6", bus.data_o, p6);
      @(negedge clk);
      @(negedge clk);

      // T5: reset while a write to idx 8 is in WAIT with cnt=5
      bus.enable_i = 1'b1;
      bus.write_i  = 1'b1;
      bus.addr_i   = 32'h100;
      bus.data_i   = {8{32'hBADB_AD00}};
      @(posedge clk);
      repeat (5) @(posedge clk);
      #2;
      chk("t5_busy_pre", 256'(bus.busy_o), 256'(1));
      rst_n = 1'b0;
      bus.enable_i = 1'b0;
      #1;
      chk("t5_busy_rst", 256'(bus.busy_o), 256'(0));
      chk("t5_data_rst", bus.data_o, 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      acks = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus.ack_o !== 1'b0 || bus.busy_o !== 1'b0) acks++;
      end
      chk("t5_no_ack", 256'(acks), 256'(0));
      run_req("t5_rd", 1'b0, 32'h100, '0, LAT, 1'b0);
      chk("t5_mem8_kept", bus.data_o, p8);
      @(negedge clk);

      // T6: low address bits ignored, upper bits alias modulo DEPTH
      run_req("t6_rd1f", 1'b0, 32'h0000_001F, '0, LAT, 1'b0);
      chk("t6_data_1f", bus.data_o, z0);
      @(negedge clk);
      // restore different value first so the alias read proves a fresh fetch
      run_req("t6_rd60", 1'b0, 32'h60, '0, LAT, 1'b0);
      @(negedge clk);
      run_req("t6_rd4000", 1'b0, 32'h0000_4000, '0, LAT, 1'b0);
      chk("t6_data_4000", bus.data_o, z0);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
